// File: rtl/stream_merge_pkg.sv
// Shared defaults and helpers for the stream_merge_rr 2-to-1 round-robin merge.
// Optional packet locking is enabled by defining PACKET_LOCK_EN.
package stream_merge_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned DEPTH_DEF    = 2;
    localparam int unsigned LAST_BIT_DEF = 31;

    typedef logic grant_t;

    // Count must hold 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Per-input circular buffer: DEPTH words, registered count drives full/empty.
// Writes while full and reads while empty are ignored.
module stream_skid_fifo
    import stream_merge_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned CNT_W = count_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-2 depth lets the pointers wrap by plain overflow.
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/stream_merge_rr.sv
// 2-to-1 round-robin stream merge with per-input buffering and registered output.
// Define PACKET_LOCK_EN to hold the grant on one input until a LAST_BIT word is issued.
module stream_merge_rr
    import stream_merge_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned LAST_BIT = LAST_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] receive_data0,
    input  logic              receive_request0,
    output logic              receive_valid0,
    input  logic [DATA_W-1:0] receive_data1,
    input  logic              receive_request1,
    output logic              receive_valid1,
    output logic [DATA_W-1:0] send_data0,
    output logic              send_request0,
    input  logic              send_valid0,
    output logic              grant
);

    logic [DATA_W-1:0] rd_data0, rd_data1, word;
    logic              empty0, empty1;
    logic              pop0, pop1, issue;
    grant_t            pick;

    logic [DATA_W-1:0] send_data_q, send_data_d;
    logic              send_req_q, send_req_d;
    grant_t            grant_q, grant_d;
    grant_t            ptr_q, ptr_d;
`ifdef PACKET_LOCK_EN
    logic              lock_q, lock_d;
`endif

    stream_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (receive_request0),
        .wr_data (receive_data0),
        .rd_en   (pop0),
        .rd_data (rd_data0),
        .full    (receive_valid0),
        .empty   (empty0)
    );

    stream_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (receive_request1),
        .wr_data (receive_data1),
        .rd_en   (pop1),
        .rd_data (rd_data1),
        .full    (receive_valid1),
        .empty   (empty1)
    );

    always_comb begin
        issue = 1'b0;
        pick  = ptr_q;
        if (send_valid0) begin
`ifdef PACKET_LOCK_EN
            // While locked, only the owning input (last granted) may issue.
            if (lock_q) begin
                pick  = ptr_q;
                issue = ptr_q ? !empty1 : !empty0;
            end else
`endif
            begin
                if (!empty0 && !empty1) begin
                    issue = 1'b1;
                    pick  = ~ptr_q;
                end else if (!empty0) begin
                    issue = 1'b1;
                    pick  = 1'b0;
                end else if (!empty1) begin
                    issue = 1'b1;
                    pick  = 1'b1;
                end
            end
        end

        pop0        = issue && !pick;
        pop1        = issue && pick;
        word        = pick ? rd_data1 : rd_data0;
        send_req_d  = issue;
        send_data_d = issue ? word : send_data_q;
        grant_d     = issue ? pick : grant_q;
        ptr_d       = issue ? pick : ptr_q;
`ifdef PACKET_LOCK_EN
        lock_d      = issue ? !word[LAST_BIT] : lock_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            send_data_q <= '0;
            send_req_q  <= 1'b0;
            grant_q     <= 1'b0;
            ptr_q       <= 1'b1;
`ifdef PACKET_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            send_data_q <= send_data_d;
            send_req_q  <= send_req_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
`ifdef PACKET_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign send_data0    = send_data_q;
    assign send_request0 = send_req_q;
    assign grant         = grant_q;

endmodule
